// File: rtl/inst_fetch.sv
// inst_fetch: program counter and fetch sequencer.
// Drives the instruction ROM address and forwards the fetched word to the decoder.
// Taken branches are resolved with zero bubbles. A branch target comes either from an
// 8-entry absolute target LUT or from PC plus a sign-extended 3-bit offset.
// The all-ones instruction word halts the sequencer until the next Start.
// Optional feature: define FETCH_PERF_EN to add the 32-bit saturating RetireCnt output.

module inst_fetch #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] StartAddr,
  input  logic         Stall,
  input  logic         BranchEn,
  input  logic         BranchRel,
  input  logic [2:0]   BranchIdx,
  input  logic         LutWrEn,
  input  logic [2:0]   LutWrIdx,
  input  logic [A-1:0] LutWrData,
  output logic [A-1:0] InstAddress,
  input  logic [W-1:0] InstIn,
  output logic [W-1:0] InstOut,
  output logic         InstValid,
  output logic         Done
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  RetireCnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic [A-1:0] lut_q [8];

  logic         isHalt;
  logic         advance;
  logic [A-1:0] relOffset;
  logic [A-1:0] branchTarget;

  // Decode the halt word, the advance condition and the branch target from current state
  always_comb begin
    isHalt       = (InstIn == {W{1'b1}});
    advance      = (state_q == RUN) && !Stall && !Start;
    relOffset    = {{(A-3){BranchIdx[2]}}, BranchIdx};
    branchTarget = BranchRel ? (pc_q + relOffset) : lut_q[BranchIdx];
  end

  // State register: Reset returns to IDLE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: Start always enters RUN; an unstalled halt word enters HALT
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (Start) begin
          state_d = RUN;
        end else if (!Stall && isHalt) begin
          state_d = HALT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the decoder only sees a word while running
  always_comb begin
    InstValid = (state_q == RUN);
    Done      = (state_q == HALT);
    InstOut   = (state_q == RUN) ? InstIn : '0;
  end

  // Next PC: Start loads StartAddr; an advancing non-halt cycle branches or increments (mod 2^A)
  always_comb begin
    pc_d = pc_q;
    if (Start) begin
      pc_d = StartAddr;
    end else if (advance && !isHalt) begin
      pc_d = BranchEn ? branchTarget : (pc_q + 1'b1);
    end
  end

  // PC register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Target LUT: reset spreads the entries evenly over the address space; writes land at the edge
  // so a branch in the same cycle still reads the old entry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        lut_q[i] <= A'(i) << (A - 3);
      end
    end else if (LutWrEn) begin
      lut_q[LutWrIdx] <= LutWrData;
    end
  end

  assign InstAddress = pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] retireCnt_q, retireCnt_d;

  // Retired-instruction count: cleared by Start, saturating, includes the halt word
  always_comb begin
    retireCnt_d = retireCnt_q;
    if (Start) begin
      retireCnt_d = '0;
    end else if (advance && (retireCnt_q != 32'hFFFF_FFFF)) begin
      retireCnt_d = retireCnt_q + 32'd1;
    end
  end

  // Retire counter register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      retireCnt_q <= '0;
    end else begin
      retireCnt_q <= retireCnt_d;
    end
  end

  assign RetireCnt = retireCnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch.
// The stimulus process drives one cycle at a time and queues the outputs expected after that edge.
// A monitor process pops and compares them on each falling edge.

module tb_inst_fetch;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        Stall;
  logic        BranchEn;
  logic        BranchRel;
  logic [2:0]  BranchIdx;
  logic        LutWrEn;
  logic [2:0]  LutWrIdx;
  logic [9:0]  LutWrData;
  logic [9:0]  InstAddress;
  logic [8:0]  InstIn;
  logic [8:0]  InstOut;
  logic        InstValid;
  logic        Done;
`ifdef FETCH_PERF_EN
  logic [31:0] RetireCnt;
`endif

  logic [8:0]  rom [1024];

  typedef struct {
    logic [9:0]  addr;
    logic        valid;
    logic        done;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t sbQ [$];
  int   checks = 0;
  int   errors = 0;

  inst_fetch #(.A(10), .W(9)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .Stall      (Stall),
    .BranchEn   (BranchEn),
    .BranchRel  (BranchRel),
    .BranchIdx  (BranchIdx),
    .LutWrEn    (LutWrEn),
    .LutWrIdx   (LutWrIdx),
    .LutWrData  (LutWrData),
    .InstAddress(InstAddress),
    .InstIn     (InstIn),
    .InstOut    (InstOut),
    .InstValid  (InstValid),
    .Done       (Done)
`ifdef FETCH_PERF_EN
    ,
    .RetireCnt  (RetireCnt)
`endif
  );

  assign InstIn = rom[InstAddress];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Global time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic clearInputs();
    Reset     = 1'b0;
    Start     = 1'b0;
    Stall     = 1'b0;
    BranchEn  = 1'b0;
    BranchRel = 1'b0;
    BranchIdx = 3'd0;
    LutWrEn   = 1'b0;
    LutWrIdx  = 3'd0;
    LutWrData = 10'd0;
  endtask

  // Clock the inputs currently driven, queue the outputs expected after that edge, then clear pulses
  task automatic applyStimulus(input logic [9:0] a, input logic v, input logic d,
                               input logic [31:0] c, input string n);
    exp_t e;
    @(posedge Clk);
    e.addr  = a;
    e.valid = v;
    e.done  = d;
    e.cnt   = c;
    e.name  = n;
    sbQ.push_back(e);
    #1;
    clearInputs();
  endtask

  task automatic checkOutput(input exp_t e);
    logic [8:0] expOut;
    expOut = e.valid ? rom[e.addr] : 9'd0;
    checks++;
    if (InstAddress !== e.addr) begin
      errors++;
      $display("[TB] FAIL %s addr: got %h want %h", e.name, InstAddress, e.addr);
    end
    checks++;
    if (InstValid !== e.valid) begin
      errors++;
      $display("[TB] FAIL %s valid: got %b want %b", e.name, InstValid, e.valid);
    end
    checks++;
    if (Done !== e.done) begin
      errors++;
      $display("[TB] FAIL %s done: got %b want %b", e.name, Done, e.done);
    end
    checks++;
    if (InstOut !== expOut) begin
      errors++;
      $display("[TB] FAIL %s instout: got %h want %h", e.name, InstOut, expOut);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (RetireCnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s retirecnt: got %0d want %0d", e.name, RetireCnt, e.cnt);
    end
`endif
  endtask

  // Monitor: compare every queued expectation on the falling edge after its clock edge
  always @(negedge Clk) begin
    if (sbQ.size() > 0) begin
      checkOutput(sbQ.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'(i * 7 + 1) & 9'h0FE;
    rom[8] = 9'h1FF;
    clearInputs();
    StartAddr = 10'd0;

    // Reset state
    Reset = 1'b1;
    applyStimulus(10'd0, 1'b0, 1'b0, 32'd0, "reset");
    applyStimulus(10'd0, 1'b0, 1'b0, 32'd0, "idle_hold");

    // Sequence 5..8 then halt
    Start = 1'b1; StartAddr = 10'd5;
    applyStimulus(10'd5, 1'b1, 1'b0, 32'd0, "start5");
    applyStimulus(10'd6, 1'b1, 1'b0, 32'd1, "seq6");
    applyStimulus(10'd7, 1'b1, 1'b0, 32'd2, "seq7");
    applyStimulus(10'd8, 1'b1, 1'b0, 32'd3, "seq8");
    applyStimulus(10'd8, 1'b0, 1'b1, 32'd4, "halt");
    LutWrEn = 1'b1; LutWrIdx = 3'd3; LutWrData = 10'h3F0; BranchEn = 1'b1;
    applyStimulus(10'd8, 1'b0, 1'b1, 32'd4, "halt_hold_lutwr");

    // Relative branch wrapping below zero, then increment wrapping past the top
    Start = 1'b1; StartAddr = 10'd3;
    applyStimulus(10'd3, 1'b1, 1'b0, 32'd0, "start3");
    BranchEn = 1'b1; BranchRel = 1'b1; BranchIdx = 3'b100;
    applyStimulus(10'd1023, 1'b1, 1'b0, 32'd1, "rel_wrap_neg");
    applyStimulus(10'd0, 1'b1, 1'b0, 32'd2, "inc_wrap");
    applyStimulus(10'd1, 1'b1, 1'b0, 32'd3, "inc1");

    // Same-cycle LUT write and branch reads the old entry, next branch sees the new one
    LutWrEn = 1'b1; LutWrIdx = 3'd2; LutWrData = 10'h155;
    BranchEn = 1'b1; BranchRel = 1'b0; BranchIdx = 3'd2;
    applyStimulus(10'h100, 1'b1, 1'b0, 32'd4, "lut_old");
    BranchEn = 1'b1; BranchRel = 1'b0; BranchIdx = 3'd2;
    applyStimulus(10'h155, 1'b1, 1'b0, 32'd5, "lut_new");
    BranchEn = 1'b1; BranchRel = 1'b0; BranchIdx = 3'd3;
    applyStimulus(10'h3F0, 1'b1, 1'b0, 32'd6, "lut_halt_written");

    // Stall with BranchEn holds PC, then normal increment
    Start = 1'b1; StartAddr = 10'd20;
    applyStimulus(10'd20, 1'b1, 1'b0, 32'd0, "start20");
    for (int k = 0; k < 3; k++) begin
      Stall = 1'b1; BranchEn = 1'b1; BranchRel = 1'b1; BranchIdx = 3'd3;
      applyStimulus(10'd20, 1'b1, 1'b0, 32'd0, "stall_hold");
    end
    applyStimulus(10'd21, 1'b1, 1'b0, 32'd1, "after_stall");

    // Restart mid-program, then reset mid-run
    Start = 1'b1; StartAddr = 10'd9;
    applyStimulus(10'd9, 1'b1, 1'b0, 32'd0, "start9");
    Start = 1'b1; StartAddr = 10'h40;
    applyStimulus(10'h40, 1'b1, 1'b0, 32'd0, "restart40");
    applyStimulus(10'h41, 1'b1, 1'b0, 32'd1, "seq41");
    applyStimulus(10'h42, 1'b1, 1'b0, 32'd2, "seq42");
    Reset = 1'b1; Start = 1'b1; StartAddr = 10'h77;
    applyStimulus(10'd0, 1'b0, 1'b0, 32'd0, "reset_midrun");

    // IDLE ignores branches; LUT is back to its reset contents; offset 0 self-loop
    BranchEn = 1'b1; BranchRel = 1'b0; BranchIdx = 3'd2;
    applyStimulus(10'd0, 1'b0, 1'b0, 32'd0, "idle_ignore_branch");
    Start = 1'b1; StartAddr = 10'd0;
    applyStimulus(10'd0, 1'b1, 1'b0, 32'd0, "start0");
    BranchEn = 1'b1; BranchRel = 1'b0; BranchIdx = 3'd2;
    applyStimulus(10'h100, 1'b1, 1'b0, 32'd1, "lut_reinit");
    BranchEn = 1'b1; BranchRel = 1'b1; BranchIdx = 3'd0;
    applyStimulus(10'h100, 1'b1, 1'b0, 32'd2, "self_loop");
    BranchEn = 1'b1; BranchRel = 1'b1; BranchIdx = 3'd3;
    applyStimulus(10'h103, 1'b1, 1'b0, 32'd3, "rel_plus3");

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sbQ.size() > 0; k++) @(negedge Clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending want 0", sbQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
